// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
//   Shared timing constants for the 640x480@60 raster generator.
//   Holds the eight porch/sync/visible widths, the derived line and frame
//   totals, the sync window bounds, the default sync pipeline depth and the
//   coordinate type used by every consumer of DrawX/DrawY.
// -----------------------------------------------------------------------------
package vga_pkg;

  // Horizontal timing, in pixel clocks.
  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;

  // Vertical timing, in lines.
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  // Derived totals and sync windows (sync is active for START <= n < END).
  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;   // 800
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;   // 525
  localparam int HS_START = H_VISIBLE + H_FRONT;                     // 656
  localparam int HS_END   = HS_START + H_SYNC;                       // 752
  localparam int VS_START = V_VISIBLE + V_FRONT;                     // 490
  localparam int VS_END   = VS_START + V_SYNC;                       // 492

  // Cycles from the coordinate outputs to hs/vs; matches renderers that
  // read ROM on the negedge and register colour on the posedge.
  localparam int unsigned PIPE_DELAY     = 1;
  localparam int unsigned PIPE_DELAY_MAX = 4;

  typedef logic [9:0] coord_t;

  // True when lo <= v < hi.
  function automatic logic in_window(input coord_t v, input coord_t lo,
                                     input coord_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage : vga_pkg

// File: rtl/vga_sync_delay.sv
// -----------------------------------------------------------------------------
// vga_sync_delay
//   DEPTH-stage shift register for an active-low sync line. Every stage
//   resets to 1 so the monitor never sees a sync pulse while in reset or
//   while the pipeline is filling after reset release. DEPTH=0 is a wire.
//
// Ports
//   clk     in  pixel clock
//   rst_n   in  asynchronous active-low reset
//   sync_i  in  raw sync, registered, aligned with DrawX/DrawY
//   sync_o  out sync delayed by DEPTH cycles
// -----------------------------------------------------------------------------
module vga_sync_delay #(
  parameter int unsigned DEPTH = vga_pkg::PIPE_DELAY
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sync_i,
  output logic sync_o
);

  if (DEPTH == 0) begin : g_bypass

    assign sync_o = sync_i;

  end else begin : g_pipe

    logic [DEPTH-1:0] stage_q;

    // NOTE: every stage is reset (to the inactive level) rather than left
    // uninitialised, otherwise the first DEPTH cycles after reset could
    // emit an arbitrary sync level to the monitor.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stage_q <= '1;
      end else begin
        stage_q[0] <= sync_i;
        for (int i = 1; i < int'(DEPTH); i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign sync_o = stage_q[DEPTH-1];

  end

endmodule : vga_sync_delay

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   Free-running raster timing generator (640x480@60 by default, 25 MHz).
//   All outputs are registered. The first rising edge after reset release
//   presents pixel (0,0); each later edge presents the next pixel in raster
//   order. hs/vs are decoded from the same coordinates and then delayed by
//   PIPE_DELAY cycles (legal 0..4) to line up with the renderers' colour
//   registers; the strobes and frame counter are not delayed.
//
// Ports
//   vga_clk      in  pixel clock
//   reset_n      in  asynchronous active-low reset
//   DrawX        out current column, 0..H_TOTAL-1
//   DrawY        out current line, 0..V_TOTAL-1
//   blank        out 1 = visible pixel
//   hs           out horizontal sync, active-low, delayed by PIPE_DELAY
//   vs           out vertical sync, active-low, delayed by PIPE_DELAY
//   line_start   out 1-cycle strobe with DrawX==0
//   frame_start  out 1-cycle strobe with DrawX==0 and DrawY==0
//   frame_count  out completed-frame counter, wraps modulo 256
// -----------------------------------------------------------------------------
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int          H_VISIBLE  = vga_pkg::H_VISIBLE,
  parameter int          H_FRONT    = vga_pkg::H_FRONT,
  parameter int          H_SYNC     = vga_pkg::H_SYNC,
  parameter int          H_BACK     = vga_pkg::H_BACK,
  parameter int          V_VISIBLE  = vga_pkg::V_VISIBLE,
  parameter int          V_FRONT    = vga_pkg::V_FRONT,
  parameter int          V_SYNC     = vga_pkg::V_SYNC,
  parameter int          V_BACK     = vga_pkg::V_BACK,
  parameter int unsigned PIPE_DELAY = vga_pkg::PIPE_DELAY
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output coord_t     DrawX,
  output coord_t     DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  // Geometry resolved for this instance's parameters.
  localparam int     H_TOTAL_C  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int     V_TOTAL_C  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam coord_t H_LAST     = coord_t'(H_TOTAL_C - 1);
  localparam coord_t V_LAST     = coord_t'(V_TOTAL_C - 1);
  localparam coord_t H_VIS_C    = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS_C    = coord_t'(V_VISIBLE);
  localparam coord_t HS_START_C = coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t HS_END_C   = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam coord_t VS_START_C = coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t VS_END_C   = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

  // run_q is clear only for the first edge after reset: that edge must
  // present (0,0) as a real pixel rather than advance past it, and must not
  // count as a completed frame.
  logic       run_q;
  coord_t     x_q, x_d;
  coord_t     y_q, y_d;
  logic       blank_q;
  logic       raw_hs_q;
  logic       raw_vs_q;
  logic       line_start_q;
  logic       frame_start_q;
  logic [7:0] frame_count_q, frame_count_d;

  // Next pixel position and frame count.
  // NOTE: every variable gets a default at the top of the block so no path
  // leaves one unassigned, which would infer a latch.
  always_comb begin
    x_d           = '0;
    y_d           = '0;
    frame_count_d = frame_count_q;

    if (run_q) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + coord_t'(1);
      end else begin
        x_d = x_q + coord_t'(1);
        y_d = y_q;
      end

      // Wrap back to the origin from a running raster = one frame done.
      if ((x_d == '0) && (y_d == '0)) begin
        frame_count_d = frame_count_q + 8'd1;
      end
    end
  end

  // Coordinates and everything decoded from them are registered together,
  // so blank, strobes and raw sync are aligned with DrawX/DrawY.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q         <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      blank_q       <= 1'b0;
      raw_hs_q      <= 1'b1;
      raw_vs_q      <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      run_q         <= 1'b1;
      x_q           <= x_d;
      y_q           <= y_d;
      blank_q       <= (x_d < H_VIS_C) && (y_d < V_VIS_C);
      raw_hs_q      <= !in_window(x_d, HS_START_C, HS_END_C);
      // Depends on y only, so it can change only when x wraps to 0.
      raw_vs_q      <= !in_window(y_d, VS_START_C, VS_END_C);
      line_start_q  <= (x_d == '0);
      frame_start_q <= (x_d == '0) && (y_d == '0);
      frame_count_q <= frame_count_d;
    end
  end

  vga_sync_delay #(
    .DEPTH (PIPE_DELAY)
  ) u_hs_delay (
    .clk    (vga_clk),
    .rst_n  (reset_n),
    .sync_i (raw_hs_q),
    .sync_o (hs)
  );

  vga_sync_delay #(
    .DEPTH (PIPE_DELAY)
  ) u_vs_delay (
    .clk    (vga_clk),
    .rst_n  (reset_n),
    .sync_i (raw_vs_q),
    .sync_o (vs)
  );

  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign blank       = blank_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule : vga_timing_gen

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//   Three generators share one clock: the default 640x480 geometry with
//   PIPE_DELAY=1, and a tiny 16x9 geometry with PIPE_DELAY=0 and =3 so that
//   whole frames (and 256 of them) fit in a short run. Expected values come
//   from raster arithmetic on k, the cycle index since reset release.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

  typedef struct packed {
    int hv; int hf; int hsw; int hb;
    int vv; int vf; int vsw; int vb;
  } geom_t;

  localparam geom_t G_DEF = '{640, 16, 96, 48, 480, 10, 2, 33};
  localparam geom_t G_SML = '{8, 2, 3, 3, 4, 1, 2, 2};   // 16 x 9

  logic clk = 1'b0;
  logic rst_main_n;
  logic rst_sml_n;

  always #5 clk = ~clk;

  logic [9:0] m_x, m_y, a_x, a_y, b_x, b_y;
  logic       m_blank, m_hs, m_vs, m_ls, m_fs;
  logic       a_blank, a_hs, a_vs, a_ls, a_fs;
  logic       b_blank, b_hs, b_vs, b_ls, b_fs;
  logic [7:0] m_fc, a_fc, b_fc;

  vga_timing_gen #(.PIPE_DELAY(1)) u_main (
    .vga_clk(clk), .reset_n(rst_main_n), .DrawX(m_x), .DrawY(m_y),
    .blank(m_blank), .hs(m_hs), .vs(m_vs), .line_start(m_ls),
    .frame_start(m_fs), .frame_count(m_fc)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .PIPE_DELAY(0)
  ) u_sml0 (
    .vga_clk(clk), .reset_n(rst_sml_n), .DrawX(a_x), .DrawY(a_y),
    .blank(a_blank), .hs(a_hs), .vs(a_vs), .line_start(a_ls),
    .frame_start(a_fs), .frame_count(a_fc)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .PIPE_DELAY(3)
  ) u_sml3 (
    .vga_clk(clk), .reset_n(rst_sml_n), .DrawX(b_x), .DrawY(b_y),
    .blank(b_blank), .hs(b_hs), .vs(b_vs), .line_start(b_ls),
    .frame_start(b_fs), .frame_count(b_fc)
  );

  // Observed output bundles: {x, y, blank, line_start, frame_start, hs, vs, fc}
  wire [32:0] m_vec = {m_x, m_y, m_blank, m_ls, m_fs, m_hs, m_vs, m_fc};
  wire [32:0] a_vec = {a_x, a_y, a_blank, a_ls, a_fs, a_hs, a_vs, a_fc};
  wire [32:0] b_vec = {b_x, b_y, b_blank, b_ls, b_fs, b_hs, b_vs, b_fc};

  int errors = 0;
  int checks = 0;
  int km;   // cycle index of the main generator
  int ks;   // cycle index of the two small generators

  // ---------------- reference model: raster arithmetic ----------------
  function automatic int htot(geom_t g);
    return g.hv + g.hf + g.hsw + g.hb;
  endfunction

  function automatic int vtot(geom_t g);
    return g.vv + g.vf + g.vsw + g.vb;
  endfunction

  function automatic int ex_x(geom_t g, int k);
    return k % htot(g);
  endfunction

  function automatic int ex_y(geom_t g, int k);
    return (k / htot(g)) % vtot(g);
  endfunction

  // Sync seen at cycle k is the raw decode of pixel k-pd; before the
  // pipeline has filled it is the inactive level.
  function automatic logic ex_hs(geom_t g, int k, int pd);
    int x;
    if (k - pd < 0) return 1'b1;
    x = ex_x(g, k - pd);
    return !((x >= g.hv + g.hf) && (x < g.hv + g.hf + g.hsw));
  endfunction

  function automatic logic ex_vs(geom_t g, int k, int pd);
    int y;
    if (k - pd < 0) return 1'b1;
    y = ex_y(g, k - pd);
    return !((y >= g.vv + g.vf) && (y < g.vv + g.vf + g.vsw));
  endfunction

  function automatic logic [32:0] ex_vec(geom_t g, int k, int pd);
    int x, y, fc;
    x  = ex_x(g, k);
    y  = ex_y(g, k);
    fc = (k / (htot(g) * vtot(g))) % 256;
    return {10'(x), 10'(y), (x < g.hv) && (y < g.vv), x == 0,
            (x == 0) && (y == 0), ex_hs(g, k, pd), ex_vs(g, k, pd), 8'(fc)};
  endfunction

  // Advance one pixel clock and sample on the falling edge.
  task automatic tick();
    @(negedge clk);
    km++;
    ks++;
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset();
    rst_main_n = 1'b0;
    rst_sml_n  = 1'b0;
    repeat (4) @(negedge clk);
    if (m_vec !== {10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0}) begin
      errors++;
      $display("FAIL reset_main got=%h exp=%h", m_vec, {20'd0, 5'b00011, 8'd0});
    end
    checks++;
    if (b_vec !== {10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0}) begin
      errors++;
      $display("FAIL reset_pd3 got=%h exp=%h", b_vec, {20'd0, 5'b00011, 8'd0});
    end
    checks++;
  endtask

  // First two lines of the default raster, every output, every cycle.
  task automatic test_first_lines();
    int  fall_k = -1;
    int  rise_k = -1;
    int  low_cnt = 0;
    logic prev_hs = 1'b1;
    rst_main_n = 1'b1;
    rst_sml_n  = 1'b1;
    km = -1;
    ks = -1;
    for (int n = 0; n < 1700; n++) begin
      tick();
      if (m_vec !== ex_vec(G_DEF, km, 1)) begin
        errors++;
        $display("FAIL raster_k%0d got=%h exp=%h", km, m_vec, ex_vec(G_DEF, km, 1));
      end
      checks++;
      if (km == 0) begin
        if ({m_x, m_y, m_blank, m_ls, m_fs} !== {20'd0, 3'b111}) begin
          errors++;
          $display("FAIL first_pixel got=%h exp=%h", {m_x, m_y, m_blank, m_ls, m_fs}, {20'd0, 3'b111});
        end
        checks++;
      end
      if (km == 639 || km == 640) begin
        if (m_blank !== (km == 639)) begin
          errors++;
          $display("FAIL blank_edge_k%0d got=%b exp=%b", km, m_blank, km == 639);
        end
        checks++;
      end
      if (km == 800) begin
        if ({m_x, m_y} !== {10'd0, 10'd1}) begin
          errors++;
          $display("FAIL line_wrap got=(%0d,%0d) exp=(0,1)", m_x, m_y);
        end
        checks++;
      end
      if (km < 800) begin
        if (prev_hs && !m_hs && fall_k < 0) fall_k = km;
        if (!prev_hs && m_hs && rise_k < 0) rise_k = km;
        if (!m_hs) low_cnt++;
      end
      prev_hs = m_hs;
    end
    if (fall_k !== 657) begin
      errors++;
      $display("FAIL hs_fall got=%0d exp=657", fall_k);
    end
    checks++;
    if (rise_k !== 753) begin
      errors++;
      $display("FAIL hs_rise got=%0d exp=753", rise_k);
    end
    checks++;
    if (low_cnt !== 96) begin
      errors++;
      $display("FAIL hs_width got=%0d exp=96", low_cnt);
    end
    checks++;
  endtask

  // Random jumps through the default raster.
  task automatic test_random_points();
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(1, 900)) tick();
      if (m_vec !== ex_vec(G_DEF, km, 1)) begin
        errors++;
        $display("FAIL rand_point_k%0d got=%h exp=%h", km, m_vec, ex_vec(G_DEF, km, 1));
      end
      checks++;
    end
  endtask

  // Asynchronous reset while hs is low, then a clean restart.
  task automatic test_mid_frame_reset();
    int target_x = int'($urandom_range(670, 740));
    int budget   = 2000;
    while (ex_x(G_DEF, km) != target_x && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) begin
      errors++;
      $display("FAIL reset_point_timeout got=%0d exp=%0d", ex_x(G_DEF, km), target_x);
    end
    checks++;
    if (m_hs !== 1'b0) begin
      errors++;
      $display("FAIL hs_mid_pulse got=%b exp=0", m_hs);
    end
    checks++;
    #2 rst_main_n = 1'b0;
    #1;
    if (m_vec !== {10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0}) begin
      errors++;
      $display("FAIL async_reset got=%h exp=%h", m_vec, {20'd0, 5'b00011, 8'd0});
    end
    checks++;
    repeat ($urandom_range(2, 10)) begin
      tick();
      if ({m_hs, m_vs} !== 2'b11) begin
        errors++;
        $display("FAIL sync_in_reset got=%b%b exp=11", m_hs, m_vs);
      end
      checks++;
    end
    rst_main_n = 1'b1;
    km = -1;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (m_vec !== ex_vec(G_DEF, km, 1)) begin
        errors++;
        $display("FAIL restart_k%0d got=%h exp=%h", km, m_vec, ex_vec(G_DEF, km, 1));
      end
      checks++;
    end
  endtask

  // Small raster, PIPE_DELAY 0 vs 3: full compare plus edge offset.
  task automatic test_pipe_delay();
    int   a_hf = -1, b_hf = -1, a_vf = -1, b_vf = -1;
    int   a_hf_x = -1;
    logic pa_hs = a_hs, pb_hs = b_hs, pa_vs = a_vs, pb_vs = b_vs;
    for (int n = 0; n < 3 * 144; n++) begin
      tick();
      if (a_vec !== ex_vec(G_SML, ks, 0)) begin
        errors++;
        $display("FAIL pd0_k%0d got=%h exp=%h", ks, a_vec, ex_vec(G_SML, ks, 0));
      end
      checks++;
      if (b_vec !== ex_vec(G_SML, ks, 3)) begin
        errors++;
        $display("FAIL pd3_k%0d got=%h exp=%h", ks, b_vec, ex_vec(G_SML, ks, 3));
      end
      checks++;
      if (pa_hs && !a_hs && a_hf < 0) begin a_hf = ks; a_hf_x = int'(a_x); end
      if (pb_hs && !b_hs && a_hf >= 0 && b_hf < 0) b_hf = ks;
      if (pa_vs && !a_vs && a_vf < 0) a_vf = ks;
      if (pb_vs && !b_vs && a_vf >= 0 && b_vf < 0) b_vf = ks;
      pa_hs = a_hs; pb_hs = b_hs; pa_vs = a_vs; pb_vs = b_vs;
    end
    if (a_hf_x !== 10) begin
      errors++;
      $display("FAIL pd0_hs_align got=%0d exp=10", a_hf_x);
    end
    checks++;
    if (b_hf - a_hf !== 3) begin
      errors++;
      $display("FAIL pd3_hs_shift got=%0d exp=3", b_hf - a_hf);
    end
    checks++;
    if (b_vf - a_vf !== 3) begin
      errors++;
      $display("FAIL pd3_vs_shift got=%0d exp=3", b_vf - a_vf);
    end
    checks++;
  endtask

  // Run the small raster past 256 frames: counter wrap and strobe rate.
  task automatic test_frame_wrap();
    int   target  = 257 * 144 + 20;
    int   start_k = ks;
    int   pulses  = 0;
    int   exp_p   = 0;
    logic wrapped = 1'b0;
    logic [7:0] prev_fc = a_fc;
    while (ks < target) begin
      tick();
      if (a_vec !== ex_vec(G_SML, ks, 0)) begin
        errors++;
        $display("FAIL wrap_run_k%0d got=%h exp=%h", ks, a_vec, ex_vec(G_SML, ks, 0));
      end
      checks++;
      if (a_fs) pulses++;
      if (ks % 144 == 0) exp_p++;
      if (prev_fc == 8'd255 && a_fc == 8'd0) wrapped = 1'b1;
      prev_fc = a_fc;
    end
    if (pulses !== exp_p) begin
      errors++;
      $display("FAIL frame_pulses from_k%0d got=%0d exp=%0d", start_k, pulses, exp_p);
    end
    checks++;
    if (wrapped !== 1'b1) begin
      errors++;
      $display("FAIL fc_wrap got=%b exp=1", wrapped);
    end
    checks++;
    if (a_fc !== 8'd1) begin
      errors++;
      $display("FAIL fc_after_wrap got=%0d exp=1", a_fc);
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_first_lines();
    test_random_points();
    test_mid_frame_reset();
    test_pipe_delay();
    test_frame_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_vga_timing_gen
